// File: rtl/wb_commit_regfile_pkg.sv
// Shared widths, constants and load-format helpers for the WB commit stage.
package wb_commit_regfile_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
  typedef logic [2*REG_W-1:0]    double_reg_bus_t;
  typedef logic [3:0]            data_we_bus_t;

  localparam reg_bus_t        ZERO_WORD       = '0;
  localparam double_reg_bus_t ZERO_DWORD      = '0;
  localparam logic            WRITE_ENABLE    = 1'b1;
  localparam logic            WRITE_DISABLE   = 1'b0;
  // Active-high level of this block's reset; the older active-low reset level
  // is deliberately not shared here.
  localparam logic            RST_ACTIVE_HIGH = 1'b1;

  // Byte-lane masks that select a load width.
  localparam data_we_bus_t DRE_WORD = 4'b1111;
  localparam data_we_bus_t DRE_B0   = 4'b0001;
  localparam data_we_bus_t DRE_B1   = 4'b0010;
  localparam data_we_bus_t DRE_B2   = 4'b0100;
  localparam data_we_bus_t DRE_B3   = 4'b1000;
  localparam data_we_bus_t DRE_HLO  = 4'b0011;
  localparam data_we_bus_t DRE_HHI  = 4'b1100;

  function automatic reg_bus_t ext_byte(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic reg_bus_t ext_half(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: picks byte/half/word lanes of the raw memory
// word and extends them. Unsupported masks return zero.
module wb_load_fmt
  import wb_commit_regfile_pkg::*;
(
  input  reg_bus_t     dm_rdata,
  input  data_we_bus_t wb_dre,
  input  logic         wb_ld_signed,
  output reg_bus_t     ld_word
);

  // Lane select and extension by byte-enable mask
  always_comb begin
    ld_word = ZERO_WORD;
    case (wb_dre)
      DRE_WORD: ld_word = dm_rdata;
      DRE_B0:   ld_word = ext_byte(dm_rdata[7:0],   wb_ld_signed);
      DRE_B1:   ld_word = ext_byte(dm_rdata[15:8],  wb_ld_signed);
      DRE_B2:   ld_word = ext_byte(dm_rdata[23:16], wb_ld_signed);
      DRE_B3:   ld_word = ext_byte(dm_rdata[31:24], wb_ld_signed);
      DRE_HLO:  ld_word = ext_half(dm_rdata[15:0],  wb_ld_signed);
      DRE_HHI:  ld_word = ext_half(dm_rdata[31:16], wb_ld_signed);
      default:  ld_word = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/wb_commit_regfile.sv
// WB-stage commit: GPR file with $0 hardwired, HI/LO, write-through bypass on
// all read paths, and a counter of cycles that commit architectural state.
module wb_commit_regfile
  import wb_commit_regfile_pkg::*;
#(
  parameter int DATA_W  = REG_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int REG_NUM = 32
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst,
  input  logic [ADDR_W-1:0]   wb_wa,
  input  logic                wb_wreg,
  input  logic                wb_mreg,
  input  logic [DATA_W-1:0]   wb_dreg,
  input  logic [3:0]          wb_dre,
  input  logic                wb_ld_signed,
  input  logic [DATA_W-1:0]   dm_rdata,
  input  logic                wb_whilo,
  input  logic [2*DATA_W-1:0] wb_dhilo,
  input  logic                re1,
  input  logic [ADDR_W-1:0]   ra1,
  output logic [DATA_W-1:0]   rd1,
  input  logic                re2,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd2,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic [31:0]         commit_cnt
);

  logic [DATA_W-1:0] gpr_q [REG_NUM];
  logic [DATA_W-1:0] gpr_d [REG_NUM];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] fmt_word, wdata;
  logic              rst_on, gpr_commit, hilo_commit;

  wb_load_fmt u_load_fmt (
    .dm_rdata     (dm_rdata),
    .wb_dre       (wb_dre),
    .wb_ld_signed (wb_ld_signed),
    .ld_word      (fmt_word)
  );

  // Write data select and commit qualification ($0 writes are dropped, and
  // reset suppresses every commit in its cycle)
  always_comb begin
    rst_on      = (cpu_rst == RST_ACTIVE_HIGH);
    wdata       = wb_mreg ? fmt_word : wb_dreg;
    gpr_commit  = !rst_on && (wb_wreg == WRITE_ENABLE) && (wb_wa != '0);
    hilo_commit = !rst_on && (wb_whilo == WRITE_ENABLE);
  end

  // Next architectural state; a GPR and a HI/LO commit together count once
  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (gpr_commit) gpr_d[wb_wa] = wdata;
    if (hilo_commit) begin
      hi_d = wb_dhilo[2*DATA_W-1:DATA_W];
      lo_d = wb_dhilo[DATA_W-1:0];
    end
    if (gpr_commit || hilo_commit) cnt_d = cnt_q + 32'd1;
  end

  // State registers with synchronous reset
  always_ff @(posedge cpu_clk_50M) begin
    if (rst_on) begin
      for (int i = 0; i < REG_NUM; i++) gpr_q[i] <= '0;
      {hi_q, lo_q} <= ZERO_DWORD;
      cnt_q        <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  // Read ports and HI/LO with same-cycle write-through; all forced low in reset
  always_comb begin
    rd1  = '0;
    rd2  = '0;
    hi_o = '0;
    lo_o = '0;
    if (!rst_on) begin
      if (re1 && ra1 != '0) rd1 = (wb_wreg && ra1 == wb_wa) ? wdata : gpr_q[ra1];
      if (re2 && ra2 != '0) rd2 = (wb_wreg && ra2 == wb_wa) ? wdata : gpr_q[ra2];
      hi_o = wb_whilo ? wb_dhilo[2*DATA_W-1:DATA_W] : hi_q;
      lo_o = wb_whilo ? wb_dhilo[DATA_W-1:0]        : lo_q;
    end
  end

  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Scoreboard bench for wb_commit_regfile: a reference model predicts each
// cycle's outputs, pushes them, and each test pops and compares.
module tb_wb_commit_regfile;

  logic        clk = 1'b0;
  logic        rst, wreg, mreg, sgn, whilo, re1, re2;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] dreg, dmr;
  logic [3:0]  dre;
  logic [63:0] dhilo;
  logic [31:0] rd1, rd2, hi, lo, cnt;

  always #5 clk = ~clk;

  wb_commit_regfile dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .wb_wa(wa), .wb_wreg(wreg), .wb_mreg(mreg),
    .wb_dreg(dreg), .wb_dre(dre), .wb_ld_signed(sgn), .dm_rdata(dmr),
    .wb_whilo(whilo), .wb_dhilo(dhilo), .re1(re1), .ra1(ra1), .rd1(rd1),
    .re2(re2), .ra2(ra2), .rd2(rd2), .hi_o(hi), .lo_o(lo), .commit_cnt(cnt)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, hi, lo, cnt;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        act, e;
  int          n_cmp = 0, n_err = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_cnt;

  function automatic logic [31:0] fmt_m(input logic [31:0] d, input logic [3:0] m, input logic s);
    case (m)
      4'b1111: return d;
      4'b0001: return s ? {{24{d[7]}},  d[7:0]}   : {24'h0, d[7:0]};
      4'b0010: return s ? {{24{d[15]}}, d[15:8]}  : {24'h0, d[15:8]};
      4'b0100: return s ? {{24{d[23]}}, d[23:16]} : {24'h0, d[23:16]};
      4'b1000: return s ? {{24{d[31]}}, d[31:24]} : {24'h0, d[31:24]};
      4'b0011: return s ? {{16{d[15]}}, d[15:0]}  : {16'h0, d[15:0]};
      4'b1100: return s ? {{16{d[31]}}, d[31:16]} : {16'h0, d[31:16]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_m(input logic re, input logic [4:0] ra, input logic [31:0] wd);
    if (rst || !re || ra == 5'd0) return 32'h0;
    if (wreg && ra == wa) return wd;
    return m_gpr[ra];
  endfunction

  // One cycle: predict and push, sample mid-cycle, clock, update model.
  task automatic step();
    obs_t x;
    logic [31:0] wd;
    logic gc;
    wd    = mreg ? fmt_m(dmr, dre, sgn) : dreg;
    x.rd1 = rd_m(re1, ra1, wd);
    x.rd2 = rd_m(re2, ra2, wd);
    x.hi  = rst ? 32'h0 : (whilo ? dhilo[63:32] : m_hi);
    x.lo  = rst ? 32'h0 : (whilo ? dhilo[31:0]  : m_lo);
    x.cnt = m_cnt;
    exp_q.push_back(x);
    #2;
    act = {rd1, rd2, hi, lo, cnt};
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 0; m_lo = 0; m_cnt = 0;
    end else begin
      gc = wreg && wa != 5'd0;
      if (gc) m_gpr[wa] = wd;
      if (whilo) {m_hi, m_lo} = dhilo;
      if (gc || whilo) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wreg = 0; mreg = 0; sgn = 0; whilo = 0; re1 = 0; re2 = 0;
    wa = 0; ra1 = 0; ra2 = 0; dreg = 0; dmr = 0; dre = 0; dhilo = 0;
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 4; i++) begin
      idle(); wreg = 1; wa = 5'(i); dreg = $urandom; whilo = (i == 4); dhilo = {$urandom, $urandom};
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL reset_prefill%0d act=%h exp=%h", i, act, e); end
    end
    idle(); rst = 1; re1 = 1; ra1 = 1; re2 = 1; ra2 = 2; wreg = 1; wa = 1; dreg = 32'h5555;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd1 !== 32'h0 || act.rd2 !== 32'h0 || act.hi !== 32'h0)
      begin n_err++; $display("FAIL reset_forced act=%h exp=%h", act, e); end
    for (int i = 1; i <= 4; i += 2) begin
      idle(); re1 = 1; ra1 = 5'(i); re2 = 1; ra2 = 5'(i + 1);
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (act !== e || act !== obs_t'(0)) begin n_err++; $display("FAIL reset_cleared%0d act=%h exp=0", i, act); end
    end
  endtask

  task automatic test_bypass();
    idle(); wreg = 1; wa = 5; dreg = 32'hDEADBEEF; re1 = 1; ra1 = 5; ra2 = 5;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd1 !== 32'hDEADBEEF || act.rd2 !== 32'h0)
      begin n_err++; $display("FAIL bypass_same act=%h exp=%h", act, e); end
    idle(); re1 = 1; ra1 = 5; re2 = 1; ra2 = 5;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd1 !== 32'hDEADBEEF || act.rd2 !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL bypass_after act=%h exp=%h", act, e); end
  endtask

  task automatic test_zero();
    logic [31:0] c0;
    c0 = m_cnt;
    idle(); wreg = 1; wa = 0; dreg = 32'h1234; re1 = 1; ra1 = 0;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd1 !== 32'h0) begin n_err++; $display("FAIL zero_write act=%h exp=%h", act, e); end
    idle(); re1 = 1; ra1 = 0;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd1 !== 32'h0 || act.cnt !== c0)
      begin n_err++; $display("FAIL zero_cnt act=%h exp=%h cnt_req=%h", act, e, c0); end
  endtask

  task automatic test_loads();
    logic [3:0]  m [6] = '{4'b1000, 4'b1000, 4'b0011, 4'b1100, 4'b0101, 4'b0000};
    logic        s [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] r [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F02, 32'hFFFF80F1, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      idle(); wreg = 1; mreg = 1; wa = 10; dmr = 32'h80F17F02; dre = m[i]; sgn = s[i];
      dreg = 32'hA5A5A5A5; re1 = 1; ra1 = 10;
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (act !== e || act.rd1 !== r[i])
        begin n_err++; $display("FAIL load%0d dre=%b act=%h exp=%h req=%h", i, m[i], act.rd1, e.rd1, r[i]); end
    end
    idle(); re2 = 1; ra2 = 10;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd2 !== 32'h0) begin n_err++; $display("FAIL load_stored act=%h exp=%h", act, e); end
  endtask

  task automatic test_hilo();
    logic [31:0] c0;
    c0 = m_cnt;
    idle(); whilo = 1; dhilo = 64'h11112222_33334444; wreg = 1; wa = 3; dreg = 32'h33;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.hi !== 32'h11112222 || act.lo !== 32'h33334444)
      begin n_err++; $display("FAIL hilo_bypass act=%h exp=%h", act, e); end
    idle(); re1 = 1; ra1 = 3;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.cnt !== c0 + 1 || act.hi !== 32'h11112222 || act.rd1 !== 32'h33)
      begin n_err++; $display("FAIL hilo_once act=%h exp=%h", act, e); end
  endtask

  task automatic test_reset_collision();
    idle(); wreg = 1; wa = 7; dreg = 32'h77;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL coll_pre act=%h exp=%h", act, e); end
    idle(); rst = 1; wreg = 1; wa = 7; dreg = 32'hABCD; whilo = 1; dhilo = 64'h1;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL coll_rst act=%h exp=%h", act, e); end
    idle(); re1 = 1; ra1 = 7;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.rd1 !== 32'h0 || act.cnt !== 32'h0 || act.lo !== 32'h0)
      begin n_err++; $display("FAIL coll_after act=%h exp=%h", act, e); end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    idle(); wreg = 1; wa = 9; dreg = 32'h99;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.cnt !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_pre act=%h exp=%h", act, e); end
    idle();
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.cnt !== 32'h0) begin n_err++; $display("FAIL wrap act=%h req=0", act.cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      idle();
      wreg = $urandom_range(0, 1); mreg = $urandom_range(0, 1); whilo = ($urandom_range(0, 3) == 0);
      wa = 5'($urandom_range(0, 7)); dreg = $urandom; dmr = $urandom;
      dre = 4'($urandom_range(0, 15)); sgn = $urandom_range(0, 1); dhilo = {$urandom, $urandom};
      re1 = ($urandom_range(0, 3) != 0); re2 = ($urandom_range(0, 3) != 0);
      ra1 = 5'($urandom_range(0, 7)); ra2 = 5'($urandom_range(0, 7));
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL random%0d act=%h exp=%h", i, act, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 0; m_lo = 0; m_cnt = 0;
    idle(); rst = 1;
    @(negedge clk);
    step();
    e = exp_q.pop_front();
    idle(); re1 = 1; ra1 = 1;
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (act !== e || act.cnt !== 32'h0) begin n_err++; $display("FAIL init act=%h exp=%h", act, e); end
    test_reset();
    test_bypass();
    test_zero();
    test_loads();
    test_hilo();
    test_reset_collision();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
